stim_driver: RTL
================

Name: stim_driver

Overview:
Stimulus source for the FRANK6000 test environment. It is the driving end that pairs with the result checker.
- Holds a small vector memory of {stimulus, expected} pairs.
- Issues each stimulus to the DUT over a valid/ready handshake and presents the matching expected value alongside it for the checker.
- Waits for the DUT's response strobe before advancing to the next vector.
- Reports progress, completion and timeout.

Parameters:
WIDTH, 8, data width of stimulus and expected values
DEPTH, 16, number of vector memory entries (power of two)
ADDR_W, 4, log2(DEPTH)
TIMEOUT, 255, max cycles to wait for i_resp_valid (used only with STIM_TIMEOUT_EN)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_load_en  in  1  write one vector memory entry this cycle
i_load_addr  in  ADDR_W  entry to write
i_load_data  in  2*WIDTH  {stimulus[2W-1:W], expected[W-1:0]}
i_num_vec  in  ADDR_W+1  number of vectors to run; values >DEPTH saturate to DEPTH
i_start  in  1  start pulse
i_ready  in  1  DUT accepts stimulus
i_resp_valid  in  1  DUT result available (single-cycle strobe)
o_valid  out  1  stimulus valid
o_stim  out  WIDTH  stimulus value
o_expctd  out  WIDTH  expected result for the current vector
o_index  out  ADDR_W  index of the current vector
o_busy  out  1  run in progress
o_done  out  1  one-cycle pulse at end of run
o_timeout  out  1  sticky; set when a response times out

Behaviour:
- Reset (async, any time, including mid-run):
  - FSM to IDLE.
  - o_valid, o_stim, o_expctd, o_index, o_busy, o_done, o_timeout, internal vector counter and wait counter all go to 0.
  - Vector memory contents are not cleared.
- Memory write:
  - Synchronous. Accepted only in IDLE; ignored otherwise.
  - An entry written in cycle N is readable by a run started in cycle N+1.
- FSM states: IDLE, ISSUE, WAIT_RESP, DONE.
- IDLE:
  - i_start=1 latches the saturated i_num_vec and clears the counter, o_index and o_timeout.
  - Next state is ISSUE, or DONE if the count is 0.
- ISSUE:
  - o_valid=1; o_stim and o_expctd come from mem[o_index]; o_busy=1.
  - o_stim and o_expctd are registered and stable while o_valid=1 and i_ready=0.
  - The handshake completes in the cycle where o_valid and i_ready are both 1. The next cycle is WAIT_RESP with o_valid=0.
  - i_ready while not in ISSUE is ignored.
- WAIT_RESP:
  - o_busy=1. o_expctd holds the current vector's expected value.
  - On i_resp_valid, the counter increments. If counter+1 equals the count, next state is DONE; otherwise o_index increments and the next state is ISSUE.
  - i_resp_valid in any other state is ignored.
  - An i_resp_valid in the same cycle as the ISSUE handshake is ignored; the response must come at least one cycle after acceptance.
- DONE:
  - Lasts one cycle: o_done=1, o_busy=0, o_valid=0. Next state is IDLE.
- Latency:
  - i_start in cycle N gives o_valid=1 in cycle N+1.
  - i_resp_valid in cycle M gives o_valid=1 for the next vector, or o_done=1, in cycle M+1.
  - Minimum per-vector time is 2 cycles (accept, then response).
- i_start while o_busy=1 or in DONE is ignored.
- o_index wraps modulo DEPTH only if count equals DEPTH; it never exceeds DEPTH-1 while active.
- o_busy=1 exactly in ISSUE and WAIT_RESP.

Optional Feature:
Macro: STIM_TIMEOUT_EN
- Defined:
  - A wait counter (width clog2(TIMEOUT+1)) clears on entry to WAIT_RESP and increments each cycle without i_resp_valid.
  - When it reaches TIMEOUT, o_timeout is set (sticky until the next accepted i_start or reset) and the FSM goes to DONE. o_done pulses.
  - i_resp_valid in the same cycle the count reaches TIMEOUT wins: it counts as a response, and no timeout is flagged.
- Undefined:
  - No wait counter exists. WAIT_RESP waits indefinitely.
  - o_timeout is tied to 0.

Test Plan:
1. Load mem[0]={8'h12,8'h24}, mem[1]={8'h7F,8'hFE}, mem[2]={8'h00,8'h00}; num_vec=3; i_ready=1; respond 2 cycles after each accept. Required:
   - o_stim sequence 12, 7F, 00 with o_expctd 24, FE, 00 and o_index 0, 1, 2.
   - o_done pulses exactly once, one cycle after the 3rd response; o_busy then drops.
2. Backpressure: hold i_ready=0 for 5 cycles during vector 0. Required: o_valid=1 and o_stim=12 stay stable all 5 cycles; accept happens on the first i_ready=1 cycle.
3. num_vec=0 with i_start. Required: o_done=1 on the next cycle, o_valid never asserts. Also num_vec=20 with DEPTH=16: exactly 16 vectors issued.
4. Assert i_start, i_load_en and spurious i_resp_valid during WAIT_RESP of vector 1. Required:
   - Spurious i_resp_valid is treated as that vector's response.
   - i_start and i_load_en are ignored; memory is unchanged after the run.
5. Assert i_rst while in WAIT_RESP of vector 1. Required:
   - All outputs are 0 immediately (asynchronously).
   - After release, a new i_start runs from index 0 using the retained memory contents.
6. With STIM_TIMEOUT_EN and TIMEOUT=10, never respond. Required: o_timeout=1 and o_done pulse 10 cycles after entering WAIT_RESP. Without the macro, o_busy stays 1 indefinitely and o_timeout stays 0.

Source files
------------

// File: rtl/stim_driver.sv
// -----------------------------------------------------------------------------
// stim_driver
//
// Stimulus source for the FRANK6000 test environment, the driving end paired
// with the result checker. It holds a small memory of {stimulus, expected}
// pairs. On a start pulse it walks the memory from entry 0. Each stimulus goes
// out over a valid/ready handshake with its expected value alongside, and the
// block then waits for the DUT's response strobe before it moves to the next
// entry.
//
// Optional feature (compile-time macro STIM_TIMEOUT_EN):
//   defined   - a response wait counter aborts the run after TIMEOUT cycles
//               without i_resp_valid and sets the sticky o_timeout flag.
//   undefined - WAIT_RESP waits indefinitely and o_timeout is always 0.
//
// Ports:
//   i_clk, i_rst     clock (rising edge), asynchronous active-high reset
//   i_load_en/addr/  write one memory entry {stim, expected}. The write is
//   i_load_data      taken only while idle.
//   i_num_vec        number of vectors to run; values above DEPTH saturate
//   i_start          start pulse; taken only while idle
//   i_ready          DUT accepts the stimulus
//   i_resp_valid     single-cycle DUT result strobe
//   o_valid, o_stim  stimulus handshake
//   o_expctd         expected result of the current vector
//   o_index          index of the current vector
//   o_busy           run in progress (ISSUE or WAIT_RESP)
//   o_done           one-cycle pulse at the end of a run
//   o_timeout        sticky response-timeout flag
// -----------------------------------------------------------------------------
module stim_driver #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_load_en,
    input  logic [ADDR_W-1:0]   i_load_addr,
    input  logic [2*WIDTH-1:0]  i_load_data,
    input  logic [ADDR_W:0]     i_num_vec,
    input  logic                i_start,
    input  logic                i_ready,
    input  logic                i_resp_valid,
    output logic                o_valid,
    output logic [WIDTH-1:0]    o_stim,
    output logic [WIDTH-1:0]    o_expctd,
    output logic [ADDR_W-1:0]   o_index,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_RESP = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    // Vector memory. It has no reset, so a reset does not erase its contents.
    logic [2*WIDTH-1:0] mem [DEPTH];

    state_t             state_q, state_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;      // responses received in this run
    logic [ADDR_W:0]    num_q, num_d;      // saturated vector count of this run
    logic [ADDR_W-1:0]  index_q, index_d;
    logic [WIDTH-1:0]   stim_q, stim_d;
    logic [WIDTH-1:0]   expctd_q, expctd_d;
    logic               timeout_q, timeout_d;

    logic               mem_we;
    logic               load_rd;           // capture mem[rd_addr] into the output regs
    logic [ADDR_W-1:0]  rd_addr;
    logic [ADDR_W:0]    num_sat;

`ifdef STIM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0]  wait_q, wait_d;
`else
    // TIMEOUT only matters when the timeout feature is built in.
    logic               timeout_param_unused;
    assign timeout_param_unused = (TIMEOUT != 0);
`endif

    always_comb begin
        num_sat = (i_num_vec > DEPTH_CNT) ? DEPTH_CNT : i_num_vec;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        index_d   = index_q;
        stim_d    = stim_q;
        expctd_d  = expctd_q;
        timeout_d = timeout_q;
        mem_we    = 1'b0;
        load_rd   = 1'b0;
        rd_addr   = index_q;
`ifdef STIM_TIMEOUT_EN
        wait_d    = wait_q;
`endif

        case (state_q)
            S_IDLE: begin
                mem_we = i_load_en;
                if (i_start) begin
                    num_d     = num_sat;
                    cnt_d     = '0;
                    index_d   = '0;
                    timeout_d = 1'b0;
                    if (num_sat == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        rd_addr = '0;
                        load_rd = 1'b1;
                    end
                end
            end

            S_ISSUE: begin
                // The output registers already hold mem[index]. They stay
                // stable until the handshake completes.
                if (i_ready) begin
                    state_d = S_WAIT_RESP;
`ifdef STIM_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end
            end

            S_WAIT_RESP: begin
                if (i_resp_valid) begin
                    cnt_d = cnt_q + (ADDR_W+1)'(1);
                    if (cnt_d == num_q) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + ADDR_W'(1);
                        rd_addr = index_d;
                        load_rd = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
`ifdef STIM_TIMEOUT_EN
                // The count reaches TIMEOUT on this edge. A response in this
                // same cycle is handled above and takes priority.
                else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
`endif
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_rd) begin
            stim_d   = mem[rd_addr][2*WIDTH-1:WIDTH];
            expctd_d = mem[rd_addr][WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[i_load_addr] <= i_load_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            num_q     <= '0;
            index_q   <= '0;
            stim_q    <= '0;
            expctd_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            index_q   <= index_d;
            stim_q    <= stim_d;
            expctd_q  <= expctd_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef STIM_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    // Control outputs are decoded from the state register. The reset value
    // of that register is IDLE, so a reset clears these outputs at once.
    assign o_valid  = (state_q == S_ISSUE);
    assign o_busy   = (state_q == S_ISSUE) || (state_q == S_WAIT_RESP);
    assign o_done   = (state_q == S_DONE);
    assign o_stim   = stim_q;
    assign o_expctd = expctd_q;
    assign o_index  = index_q;

endmodule
